// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul accelerator APB front end.
// Holds address offsets, the control-register layout and the protocol FSM states.
package matmul_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_MAX_DIM    = 4;
    localparam int DEFAULT_BUS_WIDTH  = DEFAULT_MAX_DIM * DEFAULT_DATA_WIDTH;
    localparam int DEFAULT_ADDR_WIDTH = 16;

    localparam logic [4:0] OFF_CTRL  = 5'h00;
    localparam logic [4:0] OFF_AMAT  = 5'h04;
    localparam logic [4:0] OFF_BMAT  = 5'h08;
    localparam logic [4:0] OFF_FLAGS = 5'h0C;
    localparam logic [4:0] OFF_SP    = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } apb_state_t;

    // Field order is MSB first; the start bit is never stored.
    typedef struct packed {
        logic [1:0] reserved;
        logic [1:0] mDimM1;
        logic [1:0] kDimM1;
        logic [1:0] nDimM1;
        logic [1:0] dataflow;
        logic [1:0] rdTarget;
        logic [1:0] wrTarget;
        logic       mode;
        logic       start;
    } ctrl_reg_t;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB protocol sequencer: one wait state, then a single response cycle.
// o_sample marks the WAIT->RESP edge, o_commit marks the edge ending RESP.
module apb_slave_fsm
    import matmul_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready,
    output logic o_sample,
    output logic o_commit
);

    apb_state_t r_state;
    apb_state_t w_nextState;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (i_psel && i_penable) w_nextState = ST_WAIT;
            ST_WAIT: w_nextState = i_psel ? ST_RESP : ST_IDLE;
            ST_RESP: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // A master that abandons the transfer during WAIT never gets sampled.
    always_comb begin
        o_pready = (r_state == ST_RESP);
        o_commit = (r_state == ST_RESP);
        o_sample = (r_state == ST_WAIT) && i_psel;
    end

endmodule

// File: rtl/matmul_apb_slave.sv
// APB slave front end of the matmul accelerator: operand/control/flags/scratchpad
// register file, start/busy tracking and capture of engine results.
module matmul_apb_slave
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_DIM    = DEFAULT_MAX_DIM,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [BUS_WIDTH-1:0]         pwdata,
    input  logic [MAX_DIM-1:0]           pstrb,
    output logic                         pready,
    output logic                         pslverr,
    output logic [BUS_WIDTH-1:0]         prdata,
    output logic                         start,
    output logic                         busy,
    output logic [15:0]                  ctrl,
    output logic [MAX_DIM*BUS_WIDTH-1:0] mat_a,
    output logic [MAX_DIM*BUS_WIDTH-1:0] mat_b,
    input  logic                         engine_done,
    input  logic                         res_we,
    input  logic [1:0]                   res_row,
    input  logic [1:0]                   res_col,
    input  logic [BUS_WIDTH-1:0]         res_data,
    input  logic [MAX_DIM*MAX_DIM-1:0]   flags_in
);

    logic [MAX_DIM-1:0][BUS_WIDTH-1:0] r_matA;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0] r_matB;
    logic [BUS_WIDTH-1:0]              r_sp [MAX_DIM][MAX_DIM];
    ctrl_reg_t                         r_ctrl;
    logic [MAX_DIM*MAX_DIM-1:0]        r_flags;
    logic                              r_busy;
    logic                              r_start;
    logic                              r_pslverr;
    logic [BUS_WIDTH-1:0]              r_prdata;

    logic                 w_sample;
    logic                 w_commit;
    logic [4:0]           w_offset;
    logic [1:0]           w_row;
    logic [1:0]           w_col;
    logic [BUS_WIDTH-1:0] w_rdData;
    logic [BUS_WIDTH-1:0] w_laneData;
    logic                 w_err;
    logic                 w_doWrite;
    logic                 w_startReq;
    logic                 w_unusedAddr;

    apb_slave_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .i_psel    (psel),
        .i_penable (penable),
        .o_pready  (pready),
        .o_sample  (w_sample),
        .o_commit  (w_commit)
    );

    assign w_offset     = paddr[4:0];
    assign w_row        = paddr[6:5];
    assign w_col        = paddr[8:7];
    assign w_unusedAddr = ^paddr[ADDR_WIDTH-1:9];

    always_comb begin
        w_rdData = '0;
        w_err    = 1'b0;
        case (w_offset)
            OFF_CTRL: begin
                w_rdData = BUS_WIDTH'(r_ctrl);
                w_err    = pwrite && r_busy;
            end
            OFF_AMAT: begin
                w_rdData = r_matA[w_row];
                w_err    = pwrite && r_busy;
            end
            OFF_BMAT: begin
                w_rdData = r_matB[w_row];
                w_err    = pwrite && r_busy;
            end
            OFF_FLAGS: begin
                w_rdData = BUS_WIDTH'(r_flags);
                w_err    = pwrite;
            end
            OFF_SP: begin
                w_rdData = r_sp[w_row][w_col];
                w_err    = pwrite;
            end
            default: begin
                w_rdData = '0;
                w_err    = 1'b1;
            end
        endcase
        if (pwrite) w_rdData = '0;
    end

    // Unstrobed lanes are cleared, not preserved: pstrb=0 encodes a zero element.
    always_comb begin
        w_laneData = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            if (pstrb[k]) w_laneData[k*DATA_WIDTH +: DATA_WIDTH] = pwdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_doWrite  = w_commit && pwrite && !r_pslverr;
    assign w_startReq = w_doWrite && (w_offset == OFF_CTRL) && pwdata[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else if (w_sample) begin
            r_prdata  <= w_rdData;
            r_pslverr <= w_err;
        end else if (w_commit) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
            r_matA <= '0;
            r_matB <= '0;
        end else if (w_doWrite) begin
            case (w_offset)
                OFF_CTRL: r_ctrl         <= ctrl_reg_t'({pwdata[15:1], 1'b0});
                OFF_AMAT: r_matA[w_row]  <= w_laneData;
                OFF_BMAT: r_matB[w_row]  <= w_laneData;
                default:  ;
            endcase
        end
    end

    // A legal start can only be taken while idle, so it never collides with engine_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_flags <= '0;
        end else begin
            r_start <= w_startReq;
            if (w_startReq) begin
                r_busy  <= 1'b1;
                r_flags <= '0;
            end else if (r_busy) begin
                r_flags <= r_flags | flags_in;
                if (engine_done) r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    r_sp[r][c] <= '0;
                end
            end
        end else if (res_we) begin
            r_sp[res_row][res_col] <= res_data;
        end
    end

    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;
    assign start   = r_start;
    assign busy    = r_busy;
    assign ctrl    = r_ctrl;
    assign mat_a   = r_matA;
    assign mat_b   = r_matB;

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave: directed vector table, hand-written
// corner sequences and randomized traffic against a register-level model.
module tb_matmul_apb_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        start;
    logic        busy;
    logic [15:0] ctrl;
    logic [127:0] mat_a;
    logic [127:0] mat_b;
    logic        engine_done;
    logic        res_we;
    logic [1:0]  res_row;
    logic [1:0]  res_col;
    logic [31:0] res_data;
    logic [15:0] flags_in;

    int checks = 0;
    int errors = 0;

    // Register-level model of what software should see
    logic [31:0] mA [4];
    logic [31:0] mB [4];
    logic [31:0] mSp [4][4];
    logic [15:0] mCtrl;
    logic [15:0] mFlags;
    logic        mBusy;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    matmul_apb_slave dut (
        .clk         (clk),
        .rst         (rst),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata),
        .start       (start),
        .busy        (busy),
        .ctrl        (ctrl),
        .mat_a       (mat_a),
        .mat_b       (mat_b),
        .engine_done (engine_done),
        .res_we      (res_we),
        .res_row     (res_row),
        .res_col     (res_col),
        .res_data    (res_data),
        .flags_in    (flags_in)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void addVec(input logic [15:0] a, input logic w, input logic [31:0] d,
                                   input logic [3:0] s, input logic [31:0] ed, input logic ee);
        vec_t v;
        v.addr = a; v.wr = w; v.data = d; v.strb = s; v.expData = ed; v.expErr = ee;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] laneMask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic void modelReset();
        for (int r = 0; r < 4; r++) begin
            mA[r] = '0;
            mB[r] = '0;
            for (int c = 0; c < 4; c++) mSp[r][c] = '0;
        end
        mCtrl = '0; mFlags = '0; mBusy = 1'b0;
    endfunction

    function automatic void modelPredict(input logic [15:0] a, input logic wr,
                                         output logic [31:0] d, output logic e);
        int off, row, col;
        off = int'(a) % 32;
        row = (int'(a) / 32) % 4;
        col = (int'(a) / 128) % 4;
        d = '0;
        e = 1'b0;
        case (off)
            0:  if (wr) e = mBusy; else d = {16'h0, mCtrl};
            4:  if (wr) e = mBusy; else d = mA[row];
            8:  if (wr) e = mBusy; else d = mB[row];
            12: if (wr) e = 1'b1;  else d = {16'h0, mFlags};
            16: if (wr) e = 1'b1;  else d = mSp[row][col];
            default: e = 1'b1;
        endcase
    endfunction

    function automatic void modelCommit(input logic [15:0] a, input logic wr, input logic [31:0] d,
                                        input logic [3:0] s, input logic e, output logic expStart);
        int off, row;
        off = int'(a) % 32;
        row = (int'(a) / 32) % 4;
        expStart = 1'b0;
        if (wr && !e) begin
            case (off)
                0: begin
                    mCtrl = d[15:0] & 16'hFFFE;
                    if (d[0]) begin
                        mBusy = 1'b1;
                        mFlags = '0;
                        expStart = 1'b1;
                    end
                end
                4: mA[row] = laneMask(d, s);
                8: mB[row] = laneMask(d, s);
                default: ;
            endcase
        end
    endfunction

    // One full APB transfer; returns one cycle after the response (commit) edge
    task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        int cycles;
        bit seen;
        @(posedge clk); #1;
        paddr = addr; pwrite = wr; pwdata = data; pstrb = strb; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        cycles = 1; seen = 1'b0; rdata = '0; err = 1'b0;
        while (!seen && cycles <= 8) begin
            if (pready === 1'b1) begin
                seen = 1'b1;
                rdata = prdata;
                err = pslverr;
            end else begin
                @(posedge clk); #1;
                cycles++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL pready_timeout addr 0x%04h: no pready within 8 cycles, expected after 3", addr);
        end else begin
            checkOutput("latency", 32'(cycles), 32'd3);
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        checkOutput("pready_one_cycle", 32'(pready), 32'd0);
    endtask

    task automatic doTransfer(input logic [15:0] addr, input logic wr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                              output logic [31:0] expData, output logic expErr, output logic expStart);
        modelPredict(addr, wr, expData, expErr);
        applyStimulus(addr, wr, data, strb, rdata, err);
        modelCommit(addr, wr, data, strb, expErr, expStart);
    endtask

    task automatic engineCycle(input logic done, input logic we, input logic [1:0] row, input logic [1:0] col,
                               input logic [31:0] data, input logic [15:0] flags);
        @(posedge clk); #1;
        engine_done = done; res_we = we; res_row = row; res_col = col; res_data = data; flags_in = flags;
        @(posedge clk); #1;
        if (mBusy) mFlags = mFlags | flags;
        if (we) mSp[row][col] = data;
        if (done && mBusy) mBusy = 1'b0;
        engine_done = 1'b0; res_we = 1'b0; flags_in = '0;
    endtask

    initial begin
        logic [31:0] rd, expD, rdata2;
        logic        er, expE, expS, seenReady, wr;
        logic [15:0] a;
        logic [4:0]  off;
        logic [31:0] dat;
        int          kind;

        rst = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        engine_done = 1'b0; res_we = 1'b0; res_row = '0; res_col = '0; res_data = '0; flags_in = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rst_pready", 32'(pready), 32'd0);
        checkOutput("rst_pslverr", 32'(pslverr), 32'd0);
        checkOutput("rst_prdata", prdata, 32'd0);
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ctrl", 32'(ctrl), 32'd0);
        checkOutput("rst_mat_a_nonzero", 32'(|mat_a), 32'd0);
        checkOutput("rst_mat_b_nonzero", 32'(|mat_b), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed vector table");
        addVec(16'h0004, 1'b1, 32'h04030201, 4'b1111, 32'h0, 1'b0);
        addVec(16'h0004, 1'b0, 32'h0,        4'b0000, 32'h04030201, 1'b0);
        addVec(16'h0028, 1'b1, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b0);
        addVec(16'h0028, 1'b1, 32'h00020001, 4'b0101, 32'h0, 1'b0);
        addVec(16'h0028, 1'b0, 32'h0,        4'b0000, 32'h00020001, 1'b0);
        addVec(16'h0014, 1'b0, 32'h0,        4'b0000, 32'h0, 1'b1);
        addVec(16'h0001, 1'b0, 32'h0,        4'b0000, 32'h0, 1'b1);
        addVec(16'h000C, 1'b1, 32'h12345678, 4'b1111, 32'h0, 1'b1);
        addVec(16'h0010, 1'b1, 32'h12345678, 4'b1111, 32'h0, 1'b1);
        addVec(16'h0010, 1'b0, 32'h0,        4'b0000, 32'h0, 1'b0);
        addVec(16'h0000, 1'b0, 32'h0,        4'b0000, 32'h0, 1'b0);
        addVec(16'h0000, 1'b1, 32'h0000C0B6, 4'b0001, 32'h0, 1'b0);
        addVec(16'h0000, 1'b0, 32'h0,        4'b0000, 32'h0000C0B6, 1'b0);
        addVec(16'h0064, 1'b1, 32'hDEADBEEF, 4'b1010, 32'h0, 1'b0);
        addVec(16'h0064, 1'b0, 32'h0,        4'b0000, 32'hDE00BE00, 1'b0);
        addVec(16'h0044, 1'b0, 32'h0,        4'b0000, 32'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            doTransfer(vecs[i].addr, vecs[i].wr, vecs[i].data, vecs[i].strb, rd, er, expD, expE, expS);
            checkOutput($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].expErr));
            if (!vecs[i].wr) checkOutput($sformatf("vec%0d_prdata", i), rd, vecs[i].expData);
        end
        checkOutput("mat_a_row3", mat_a[3*32 +: 32], 32'hDE00BE00);
        checkOutput("mat_b_row1", mat_b[1*32 +: 32], 32'h00020001);

        $display("[TB] start, busy and engine results");
        doTransfer(16'h0000, 1'b1, 32'h00000155, 4'b0001, rd, er, expD, expE, expS);
        checkOutput("start_wr_err", 32'(er), 32'd0);
        checkOutput("start_pulse", 32'(start), 32'd1);
        checkOutput("busy_rise", 32'(busy), 32'd1);
        checkOutput("ctrl_n_field", 32'(ctrl[9:8]), 32'd1);
        @(posedge clk); #1;
        checkOutput("start_one_cycle", 32'(start), 32'd0);
        doTransfer(16'h0000, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("ctrl_readback", rd, 32'h00000154);
        doTransfer(16'h0004, 1'b1, 32'hCAFEF00D, 4'hF, rd, er, expD, expE, expS);
        checkOutput("busy_wr_a_err", 32'(er), 32'd1);
        doTransfer(16'h0004, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("busy_a_unchanged", rd, 32'h04030201);
        engineCycle(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 16'h0020);
        doTransfer(16'h000C, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("flags_sticky", rd, 32'h00000020);
        engineCycle(1'b0, 1'b1, 2'd2, 2'd1, 32'h0000001E, 16'h0);
        doTransfer(16'h00D0, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("sp_r2c1", rd, 32'h0000001E);
        checkOutput("busy_before_done", 32'(busy), 32'd1);
        engineCycle(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 16'h0);
        checkOutput("busy_fall", 32'(busy), 32'd0);
        doTransfer(16'h0000, 1'b1, 32'h00000155, 4'b0001, rd, er, expD, expE, expS);
        checkOutput("restart_pulse", 32'(start), 32'd1);
        doTransfer(16'h000C, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("flags_cleared", rd, 32'h0);
        engineCycle(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 16'h0);
        engineCycle(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 16'h0);
        checkOutput("done_idle_ignored", 32'(busy), 32'd0);

        $display("[TB] result write on the sample edge");
        engineCycle(1'b0, 1'b1, 2'd1, 2'd2, 32'hAAAA0001, 16'h0);
        fork
            applyStimulus(16'h0130, 1'b0, 32'h0, 4'h0, rdata2, er);
            begin
                repeat (3) @(posedge clk);
                #1;
                res_we = 1'b1; res_row = 2'd1; res_col = 2'd2; res_data = 32'hBBBB0002;
                @(posedge clk); #1;
                res_we = 1'b0;
            end
        join
        mSp[1][2] = 32'hBBBB0002;
        checkOutput("same_edge_old_value", rdata2, 32'hAAAA0001);
        doTransfer(16'h0130, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("same_edge_new_value", rd, 32'hBBBB0002);

        $display("[TB] psel dropped during wait state");
        @(posedge clk); #1;
        paddr = 16'h0004; pwrite = 1'b1; pwdata = 32'h99999999; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        checkOutput("drop_wait_pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        seenReady = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (pready) seenReady = 1'b1;
        end
        checkOutput("drop_no_pready", 32'(seenReady), 32'd0);
        doTransfer(16'h0004, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("drop_no_write", rd, expD);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 5);
            a = {7'($urandom), 2'($urandom), 2'($urandom), 5'h00};
            case (kind)
                0: off = 5'h00;
                1: off = 5'h04;
                2: off = 5'h08;
                3: off = 5'h0C;
                4: off = 5'h10;
                default: begin
                    off = 5'($urandom);
                    while (off inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10}) off = off + 5'd1;
                end
            endcase
            a[4:0] = off;
            wr = 1'($urandom);
            dat = $urandom;
            doTransfer(a, wr, dat, 4'($urandom), rd, er, expD, expE, expS);
            checkOutput($sformatf("rnd%0d_pslverr", n), 32'(er), 32'(expE));
            if (!wr) checkOutput($sformatf("rnd%0d_prdata", n), rd, expD);
            checkOutput($sformatf("rnd%0d_start", n), 32'(start), 32'(expS));
            checkOutput($sformatf("rnd%0d_busy", n), 32'(busy), 32'(mBusy));
            if ($urandom_range(0, 2) == 0) begin
                engineCycle(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), $urandom, 16'($urandom));
            end
        end
        for (int r = 0; r < 4; r++) begin
            checkOutput($sformatf("final_mat_a_row%0d", r), mat_a[r*32 +: 32], mA[r]);
            checkOutput($sformatf("final_mat_b_row%0d", r), mat_b[r*32 +: 32], mB[r]);
        end
        checkOutput("final_ctrl", 32'(ctrl), 32'(mCtrl));

        $display("[TB] reset during wait state");
        if (mBusy) engineCycle(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 16'h0);
        doTransfer(16'h0004, 1'b1, 32'h11223344, 4'hF, rd, er, expD, expE, expS);
        engineCycle(1'b0, 1'b1, 2'd3, 2'd3, 32'h5A5A5A5A, 16'h0);
        doTransfer(16'h0000, 1'b1, 32'h00000001, 4'h1, rd, er, expD, expE, expS);
        engineCycle(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 16'h0004);
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        paddr = 16'h0024; pwrite = 1'b0; pwdata = 32'h0; pstrb = 4'h0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_pready", 32'(pready), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_start", 32'(start), 32'd0);
        checkOutput("midrst_pslverr", 32'(pslverr), 32'd0);
        checkOutput("midrst_prdata", prdata, 32'd0);
        checkOutput("midrst_ctrl", 32'(ctrl), 32'd0);
        checkOutput("midrst_mat_a_nonzero", 32'(|mat_a), 32'd0);
        checkOutput("midrst_mat_b_nonzero", 32'(|mat_b), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        doTransfer(16'h000C, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("postrst_flags", rd, 32'h0);
        doTransfer(16'h01F0, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("postrst_sp_r3c3", rd, 32'h0);
        doTransfer(16'h0004, 1'b0, 32'h0, 4'h0, rd, er, expD, expE, expS);
        checkOutput("postrst_a_row0", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
